// File: rtl/systolic_feeder_2x2.sv
// Operand sequencer for a 2x2 output-stationary systolic array: captures A and B on start,
// then streams skewed rows of A and columns of B with registered control strobes.
module systolic_feeder_2x2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a11,
    input  logic [7:0] a12,
    input  logic [7:0] a21,
    input  logic [7:0] a22,
    input  logic [7:0] b11,
    input  logic [7:0] b12,
    input  logic [7:0] b21,
    input  logic [7:0] b22,
    output logic [7:0] side_1,
    output logic [7:0] side_2,
    output logic [7:0] ceiling_1,
    output logic [7:0] ceiling_2,
    output logic       en,
    output logic       arr_rst,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StFeed0  = 3'd2,
        StFeed1  = 3'd3,
        StFeed2  = 3'd4,
        StFlush0 = 3'd5,
        StFlush1 = 3'd6,
        StDone   = 3'd7
    } state_e;

    state_e     state_q;
    logic [7:0] a11_q, a12_q, a21_q, a22_q;
    logic [7:0] b11_q, b12_q, b21_q, b22_q;

    // Outputs are loaded with the values belonging to the state being entered, so every
    // output is a flop and lines up exactly with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a11_q     <= '0;
            a12_q     <= '0;
            a21_q     <= '0;
            a22_q     <= '0;
            b11_q     <= '0;
            b12_q     <= '0;
            b21_q     <= '0;
            b22_q     <= '0;
            side_1    <= '0;
            side_2    <= '0;
            ceiling_1 <= '0;
            ceiling_2 <= '0;
            en        <= 1'b0;
            arr_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            side_1    <= '0;
            side_2    <= '0;
            ceiling_1 <= '0;
            ceiling_2 <= '0;
            en        <= 1'b0;
            arr_rst   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a11_q   <= a11;
                        a12_q   <= a12;
                        a21_q   <= a21;
                        a22_q   <= a22;
                        b11_q   <= b11;
                        b12_q   <= b12;
                        b21_q   <= b21;
                        b22_q   <= b22;
                        arr_rst <= 1'b1;
                        state_q <= StClear;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                StClear: begin
                    side_1    <= a11_q;
                    ceiling_1 <= b11_q;
                    en        <= 1'b1;
                    state_q   <= StFeed0;
                end
                StFeed0: begin
                    side_1    <= a12_q;
                    side_2    <= a21_q;
                    ceiling_1 <= b21_q;
                    ceiling_2 <= b12_q;
                    en        <= 1'b1;
                    state_q   <= StFeed1;
                end
                StFeed1: begin
                    side_2    <= a22_q;
                    ceiling_2 <= b22_q;
                    en        <= 1'b1;
                    state_q   <= StFeed2;
                end
                StFeed2: begin
                    en      <= 1'b1;
                    state_q <= StFlush0;
                end
                StFlush0: begin
                    en      <= 1'b1;
                    state_q <= StFlush1;
                end
                StFlush1: begin
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
